// File: rtl/pipe_scoreboard_ctrl.sv
// pipe_scoreboard_ctrl
//   Scoreboard-based hazard controller for a 5-stage in-order pipeline.
//   Tracks outstanding register writes (2-bit countdown + load flag per GPR).
//   It raises data-hazard stalls, branch flushes and MEM-stage freezes.
//   It also counts stalled cycles in a saturating counter.
//
//   Build option: PIPE_FORWARD_EN
//     - defined:   only a load-use (producer one stage ahead) is a hazard.
//     - undefined: any pending write is a hazard until it leaves WB.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               ID source registers
//   id_use_rs, id_use_rt       ID instruction reads rs / rt
//   id_wr_en, id_wr_reg        ID instruction writes id_wr_reg
//   id_is_load                 ID instruction is a load
//   ex_br_taken                branch/jump in EX resolved taken
//   mem_req, mem_ready         MEM access request / completion
//   pc_en, ifid_en, exmem_en   pipeline register load enables
//   idex_bubble, ifid_flush    NOP into ID/EX, clear IF/ID
//   stall                      1 = pipeline runs, 0 = ID held
//   state                      0 = RUN, 1 = MEM_WAIT
//   stall_cnt                  saturating count of stall=0 cycles
module pipe_scoreboard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_wr_en,
  input  logic [4:0]             id_wr_reg,
  input  logic                   id_is_load,
  input  logic                   ex_br_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   exmem_en,
  output logic                   idex_bubble,
  output logic                   ifid_flush,
  output logic                   stall,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_t;

  state_t                 state_r;
  logic [1:0]             pend_r [32];
  logic [31:0]            ld_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  logic frozen_s;
  logic hazard_s;
  logic wr_s;

  // Per-register hazard test. Without forwarding, ld is only ever set while
  // pend is nonzero, so folding it in leaves the result unchanged.
  function automatic logic reg_hazard(input logic [1:0] pend, input logic ld);
`ifdef PIPE_FORWARD_EN
    reg_hazard = (pend == 2'd3) && ld;
`else
    reg_hazard = (pend != 2'd0) || ld;
`endif
  endfunction

  // Freeze detection: RUN enters on an unfinished request, MEM_WAIT holds until ready.
  always_comb begin
    frozen_s = 1'b0;
    case (state_r)
      ST_RUN:      frozen_s = mem_req && !mem_ready;
      ST_MEM_WAIT: frozen_s = !mem_ready;
      default:     frozen_s = 1'b0;
    endcase
  end

  // Data hazard on either source operand; r0 is never pending.
  always_comb begin
    hazard_s = id_valid &&
               ((id_use_rs && (id_rs != 5'd0) && reg_hazard(pend_r[id_rs], ld_r[id_rs])) ||
                (id_use_rt && (id_rt != 5'd0) && reg_hazard(pend_r[id_rt], ld_r[id_rt])));
    wr_s     = !frozen_s && !ex_br_taken && id_valid && !hazard_s &&
               id_wr_en && (id_wr_reg != 5'd0);
  end

  // Pipeline control outputs, priority: reset > freeze > branch flush > hazard.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    exmem_en    = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    stall       = 1'b1;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      exmem_en    = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      stall       = 1'b1;
    end else if (frozen_s) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      exmem_en    = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      stall       = 1'b0;
    end else if (ex_br_taken) begin
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (hazard_s) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      stall       = 1'b0;
    end else begin
      idex_bubble = 1'b0;
    end
  end

  // State, scoreboard and stall counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      ld_r        <= 32'd0;
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
      for (int r = 0; r < 32; r++) begin
        pend_r[r] <= 2'd0;
      end
    end else begin
      state_r <= frozen_s ? ST_MEM_WAIT : ST_RUN;
      // A freeze holds every entry; otherwise an issue overrides the countdown.
      if (!frozen_s) begin
        for (int r = 1; r < 32; r++) begin
          if (wr_s && (id_wr_reg == 5'(r))) begin
            pend_r[r] <= 2'd3;
            ld_r[r]   <= id_is_load;
          end else if (pend_r[r] != 2'd0) begin
            pend_r[r] <= pend_r[r] - 2'd1;
            if (pend_r[r] == 2'd1) begin
              ld_r[r] <= 1'b0;
            end else begin
              ld_r[r] <= ld_r[r];
            end
          end else begin
            pend_r[r] <= 2'd0;
          end
        end
      end else begin
        state_r <= ST_MEM_WAIT;
      end
      if (!stall && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign state     = state_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_scoreboard_ctrl.sv
// Testbench for pipe_scoreboard_ctrl: directed scenarios plus random
// stimulus, all checked against a timing-based reference model.
module tb_pipe_scoreboard_ctrl;

  localparam int W      = 5;
  localparam int CNTMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load;
  logic [4:0]   id_rs, id_rt, id_wr_reg;
  logic         ex_br_taken, mem_req, mem_ready;
  logic         pc_en, ifid_en, exmem_en, idex_bubble, ifid_flush, stall;
  logic [1:0]   state;
  logic [W-1:0] stall_cnt;

  pipe_scoreboard_ctrl #(.STALL_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .exmem_en(exmem_en), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .stall(stall), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a register is busy until the advancing-cycle count
  // reaches the moment its producer has left WB.
  int adv;
  int done_at [32];
  bit is_ld   [32];
  bit m_wait;
  int m_cnt;

  bit seen_stall, seen_bub, seen_flush;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef PIPE_FORWARD_EN
    return is_ld[r] && (adv == done_at[r] - 3);
`else
    return adv < done_at[r];
`endif
  endfunction

  task automatic model_reset();
    adv    = 0;
    m_wait = 1'b0;
    m_cnt  = 0;
    for (int r = 0; r < 32; r++) begin
      done_at[r] = 0;
      is_ld[r]   = 1'b0;
    end
  endtask

  // Compare outputs with the model at the negative edge, then advance it.
  task automatic tick();
    bit frz, haz, br;
    bit e_pc, e_if, e_ex, e_bub, e_fl, e_st;
    @(negedge clk);
    seen_stall = stall;
    seen_bub   = idex_bubble;
    seen_flush = ifid_flush;
    check_val("state", 32'(state), m_wait ? 32'd1 : 32'd0);
    check_val("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    frz = m_wait ? !mem_ready : (mem_req && !mem_ready);
    br  = ex_br_taken;
    haz = id_valid && ((id_use_rs && busy(id_rs)) || (id_use_rt && busy(id_rt)));
    if (rst) begin
      {e_pc, e_if, e_ex, e_bub, e_fl, e_st} = 6'b000111;
    end else if (frz) begin
      {e_pc, e_if, e_ex, e_bub, e_fl, e_st} = 6'b000000;
    end else if (br) begin
      {e_pc, e_if, e_ex, e_bub, e_fl, e_st} = 6'b111111;
    end else if (haz) begin
      {e_pc, e_if, e_ex, e_bub, e_fl, e_st} = 6'b001100;
    end else begin
      {e_pc, e_if, e_ex, e_bub, e_fl, e_st} = 6'b111001;
    end
    check_val("pc_en", 32'(pc_en), 32'(e_pc));
    check_val("ifid_en", 32'(ifid_en), 32'(e_if));
    check_val("exmem_en", 32'(exmem_en), 32'(e_ex));
    check_val("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    check_val("ifid_flush", 32'(ifid_flush), 32'(e_fl));
    check_val("stall", 32'(stall), 32'(e_st));
    if (rst) begin
      model_reset();
    end else begin
      if (!frz && !br && id_valid && !haz && id_wr_en && (id_wr_reg != 5'd0)) begin
        done_at[id_wr_reg] = adv + 4;
        is_ld[id_wr_reg]   = id_is_load;
      end
      if (!frz) adv++;
      if (!e_st && (m_cnt < CNTMAX)) m_cnt++;
      m_wait = frz;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_wr_en = 1'b0; id_wr_reg = 5'd0;
    id_is_load = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_prod(input logic [4:0] dst, input bit load);
    idle();
    id_valid = 1'b1; id_wr_en = 1'b1; id_wr_reg = dst; id_is_load = load;
  endtask

  task automatic set_cons(input logic [4:0] a, input logic [4:0] b, input logic [4:0] dst);
    idle();
    id_valid = 1'b1; id_use_rs = 1'b1; id_rs = a; id_use_rt = 1'b1; id_rt = b;
    id_wr_en = 1'b1; id_wr_reg = dst;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Producer followed immediately by a dependent consumer; count stall cycles.
  task automatic dep_test(input string tag, input bit load, input logic [4:0] dst,
                          input int exp_stalls);
    int nst, nbub;
    nst = 0; nbub = 0;
    set_prod(dst, load);
    tick();
    set_cons(dst, dst, 5'd20);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (seen_stall) break;
      nst++;
      if (seen_bub) nbub++;
    end
    check_val({tag, "_stalls"}, 32'(nst), 32'(exp_stalls));
    check_val({tag, "_bubbles"}, 32'(nbub), 32'(exp_stalls));
    drain();
  endtask

  initial begin
    model_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    idle();
    tick();
    check_val("post_reset_state", 32'(state), 32'd0);

`ifdef PIPE_FORWARD_EN
    dep_test("alu_use", 1'b0, 5'd3, 0);
    check_val("alu_use_cnt", 32'(stall_cnt), 32'd0);
    dep_test("load_use", 1'b1, 5'd2, 1);
    dep_test("alu_fwd", 1'b0, 5'd6, 0);
`else
    dep_test("alu_use", 1'b0, 5'd3, 3);
    check_val("alu_use_cnt", 32'(stall_cnt), 32'd3);
    dep_test("load_use", 1'b1, 5'd2, 3);
    dep_test("alu_nofwd", 1'b0, 5'd6, 3);
`endif

    // Freeze while $3 has two cycles left; it must not drain during the freeze.
    set_prod(5'd3, 1'b0);
    tick();
    idle();
    tick();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("freeze_state", 32'(state), 32'd1);
    end
    set_cons(5'd3, 5'd0, 5'd21);
    mem_req = 1'b1; mem_ready = 1'b1;
    tick();
`ifdef PIPE_FORWARD_EN
    check_val("release_stall", 32'(seen_stall), 32'd1);
`else
    check_val("release_stall", 32'(seen_stall), 32'd0);
`endif
    check_val("release_state", 32'(state), 32'd0);
    set_cons(5'd3, 5'd0, 5'd21);
    for (int i = 0; i < 3; i++) tick();
    drain();

    // Branch squashes a hazarding instruction; its write must not land.
    set_prod(5'd3, 1'b1);
    tick();
    set_cons(5'd3, 5'd3, 5'd9);
    ex_br_taken = 1'b1;
    tick();
    check_val("br_flush", 32'(seen_flush), 32'd1);
    set_cons(5'd9, 5'd9, 5'd10);
    tick();
    check_val("br_no_write", 32'(seen_stall), 32'd1);
    drain();

    // Reset in the middle of a freeze with $31 freshly pending.
    set_prod(5'd31, 1'b1);
    tick();
    idle();
    mem_req = 1'b1;
    tick();
    rst = 1'b1; mem_req = 1'b1;
    tick();
    idle();
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_cnt", 32'(stall_cnt), 32'd0);
    set_cons(5'd31, 5'd31, 5'd1);
    tick();
    check_val("rst_no_pend", 32'(seen_stall), 32'd1);
    drain();

    // Writes to $0 never create a dependency.
    set_prod(5'd0, 1'b1);
    tick();
    set_cons(5'd0, 5'd0, 5'd0);
    tick();
    check_val("r0_no_stall", 32'(seen_stall), 32'd1);
    drain();

    // Random stimulus over a small register set so hazards are frequent.
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(99) == 0);
      id_valid    = ($urandom_range(3) != 0);
      id_rs       = 5'($urandom_range(7));
      id_rt       = 5'($urandom_range(7));
      id_use_rs   = 1'($urandom_range(1));
      id_use_rt   = 1'($urandom_range(1));
      id_wr_en    = ($urandom_range(3) != 0);
      id_wr_reg   = 5'($urandom_range(7));
      id_is_load  = 1'($urandom_range(1));
      ex_br_taken = ($urandom_range(7) == 0);
      mem_req     = ($urandom_range(3) == 0);
      mem_ready   = ($urandom_range(2) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
